fht_but_stream: RTL

FHT_BUT_STREAM -- requirements
Module: fht_but_stream

---
 rtl/fht_but_stream_pkg.sv | 42 ++++
 rtl/fht_but_mac.sv | 45 ++++
 rtl/fht_but_stream.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fht_but_stream_pkg.sv
// Shared definitions for the streaming FHT butterfly.
//   D_BIT_DEF / W_BIT_DEF / T_BIT_DEF : default data, twiddle and tag widths
//   scale_e                           : per-sample output scaling mode
//   saturate() / sat_detect()         : width-parametrised signed clamp helpers
//                                       operating on a 64-bit sign-extended value
package fht_but_stream_pkg;

   localparam int unsigned D_BIT_DEF = 17;
   localparam int unsigned W_BIT_DEF = 12;
   localparam int unsigned T_BIT_DEF = 10;

   typedef enum logic {
      SCALE_SAT  = 1'b0,   // unscaled, saturate to D_BIT
      SCALE_HALF = 1'b1    // halve with round-half-up
   } scale_e;

   // Clamp v to the signed range of a w-bit number; result stays sign-extended.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int unsigned        w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)
         saturate = hi;
      else if (v < lo)
         saturate = lo;
      else
         saturate = v;
   endfunction

   // High when saturate(v, w) would alter v.
   function automatic logic sat_detect(input logic signed [63:0] v,
                                       input int unsigned        w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      sat_detect = (v > hi) || (v < lo);
   endfunction

endpackage

// File: rtl/fht_but_mac.sv
// Stage-1 product term of the FHT butterfly (combinational).
//   x1, x2  : signed operands (D_BIT)
//   cs, sn  : signed Q1.(W_BIT-1) twiddles
//   sel     : 1 = bypass, p = x1 exactly
//   p       : rounded, saturated x1*cs + x2*sn (D_BIT)
//   ovf     : saturation occurred on the twiddle path
module fht_but_mac
   import fht_but_stream_pkg::*;
#(
   parameter int unsigned D_BIT = D_BIT_DEF,
   parameter int unsigned W_BIT = W_BIT_DEF
) (
   input  logic signed [D_BIT-1:0] x1,
   input  logic signed [D_BIT-1:0] x2,
   input  logic signed [W_BIT-1:0] cs,
   input  logic signed [W_BIT-1:0] sn,
   input  logic                    sel,
   output logic signed [D_BIT-1:0] p,
   output logic                    ovf
);

   localparam int unsigned PW = D_BIT + W_BIT + 1;
   // Half an LSB of the shifted result: 2^(W_BIT-2).
   localparam logic signed [PW-1:0] RND = {{(D_BIT+2){1'b0}}, 1'b1, {(W_BIT-2){1'b0}}};

   logic signed [PW-1:0] x1e, x2e, cse, sne;
   logic signed [PW-1:0] p_full, p_shift;

   always_comb begin
      x1e     = PW'(x1);
      x2e     = PW'(x2);
      cse     = PW'(cs);
      sne     = PW'(sn);
      p_full  = x1e * cse + x2e * sne + RND;
      p_shift = p_full >>> (W_BIT - 1);
      if (sel) begin
         p   = x1;
         ovf = 1'b0;
      end else begin
         p   = D_BIT'(saturate(64'(p_shift), D_BIT));
         ovf = sat_detect(64'(p_shift), D_BIT);
      end
   end

endmodule

// File: rtl/fht_but_stream.sv
// Two-stage streaming FHT butterfly with valid/ready handshake.
//   iCLK, iRESET        : clock, async active-high reset
//   iVALID / oREADY     : input handshake (oREADY = !oVALID || iREADY)
//   iX_0..iX_2          : signed operands, iSIN/iCOS twiddles, iSEL bypass,
//                         iSCALE halve-with-rounding, iTAG sideband
//   oVALID / iREADY     : output handshake
//   oY_0, oY_1, oTAG    : sum/difference results and aligned tag
//   oOVF / iCLR_OVF     : sticky saturation flag and its synchronous clear
module fht_but_stream
   import fht_but_stream_pkg::*;
#(
   parameter int unsigned D_BIT = D_BIT_DEF,
   parameter int unsigned W_BIT = W_BIT_DEF,
   parameter int unsigned T_BIT = T_BIT_DEF
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic                    iVALID,
   output logic                    oREADY,
   input  logic signed [D_BIT-1:0] iX_0,
   input  logic signed [D_BIT-1:0] iX_1,
   input  logic signed [D_BIT-1:0] iX_2,
   input  logic signed [W_BIT-1:0] iSIN,
   input  logic signed [W_BIT-1:0] iCOS,
   input  logic                    iSEL,
   input  logic                    iSCALE,
   input  logic        [T_BIT-1:0] iTAG,
   output logic                    oVALID,
   input  logic                    iREADY,
   output logic signed [D_BIT-1:0] oY_0,
   output logic signed [D_BIT-1:0] oY_1,
   output logic        [T_BIT-1:0] oTAG,
   output logic                    oOVF,
   input  logic                    iCLR_OVF
);

   localparam int unsigned SW = D_BIT + 2;

   logic                    en;
   logic signed [D_BIT-1:0] mac_p;
   logic                    mac_ovf;

   // stage-1 registers
   logic                    v1;
   logic signed [D_BIT-1:0] p1;
   logic signed [D_BIT-1:0] x0_1;
   scale_e                  scale1;
   logic        [T_BIT-1:0] tag1;

   // stage-2 combinational results
   logic signed [SW-1:0]    s_sum, s_dif, src0, src1;
   logic signed [D_BIT-1:0] y0_n, y1_n;
   logic                    s2_ovf;
   logic                    ovf_set;

   assign en     = !oVALID || iREADY;
   assign oREADY = en;

   fht_but_mac #(
      .D_BIT (D_BIT),
      .W_BIT (W_BIT)
   ) u_mac (
      .x1  (iX_1),
      .x2  (iX_2),
      .cs  (iCOS),
      .sn  (iSIN),
      .sel (iSEL),
      .p   (mac_p),
      .ovf (mac_ovf)
   );

   // Sum/difference carry two guard bits: X0-P can reach 2^D_BIT, so even the
   // halved path is clamped to keep the extreme corner from wrapping.
   always_comb begin
      s_sum = SW'(x0_1) + SW'(p1);
      s_dif = SW'(x0_1) - SW'(p1);
      if (scale1 == SCALE_HALF) begin
         src0 = (s_sum + SW'(1)) >>> 1;
         src1 = (s_dif + SW'(1)) >>> 1;
      end else begin
         src0 = s_sum;
         src1 = s_dif;
      end
      y0_n   = D_BIT'(saturate(64'(src0), D_BIT));
      y1_n   = D_BIT'(saturate(64'(src1), D_BIT));
      s2_ovf = sat_detect(64'(src0), D_BIT) || sat_detect(64'(src1), D_BIT);
   end

   assign ovf_set = en && ((iVALID && mac_ovf) || (v1 && s2_ovf));

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         v1     <= 1'b0;
         p1     <= '0;
         x0_1   <= '0;
         scale1 <= SCALE_SAT;
         tag1   <= '0;
         oVALID <= 1'b0;
         oY_0   <= '0;
         oY_1   <= '0;
         oTAG   <= '0;
         oOVF   <= 1'b0;
      end else begin
         if (en) begin
            v1     <= iVALID;
            p1     <= mac_p;
            x0_1   <= iX_0;
            scale1 <= scale_e'(iSCALE);
            tag1   <= iTAG;
            oVALID <= v1;
            oY_0   <= y0_n;
            oY_1   <= y1_n;
            oTAG   <= tag1;
         end
         // set has priority over clear
         if (ovf_set)
            oOVF <= 1'b1;
         else if (iCLR_OVF)
            oOVF <= 1'b0;
      end
   end

endmodule
